// File: rtl/xintf_write_scheduler.sv
// xintf_write_scheduler
//   Round-robin arbiter that funnels NUM_REQ 32-bit write requesters onto the single
//   Zynq->DSP XINTF DPBRAM write port. A granted request is written as two 16-bit words
//   (low word at base, high word at base+1). The block then raises o_w_valid and waits for
//   the DSP's i_w_ready, or gives up after TIMEOUT_CYC cycles and flags o_timeout_err.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_en               grant enable (in-flight transaction always completes)
//   i_req              level request per requester
//   i_addr, i_data     packed per-requester base word address / 32-bit data
//   o_ack              one-cycle completion pulse to the granted requester
//   o_busy             transaction in progress
//   o_gnt_id           index of current/last granted requester
//   o_ram_*            DPBRAM write port (addr, ce, we, din)
//   o_w_valid          write-valid to DSP; i_w_ready is the DSP's (asynchronous) reply
//   i_err_clr          clears sticky o_timeout_err
//   o_wr_cnt           completed-transaction counter (timeouts included), wraps
module xintf_write_scheduler #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned TIMEOUT_CYC = 2000
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_en,
   input  logic [NUM_REQ-1:0]           i_req,
   input  logic [NUM_REQ*ADDR_W-1:0]    i_addr,
   input  logic [NUM_REQ*32-1:0]        i_data,
   output logic [NUM_REQ-1:0]           o_ack,
   output logic                         o_busy,
   output logic [$clog2(NUM_REQ)-1:0]   o_gnt_id,
   output logic [ADDR_W-1:0]            o_ram_addr,
   output logic                         o_ram_ce,
   output logic                         o_ram_we,
   output logic [15:0]                  o_ram_din,
   output logic                         o_w_valid,
   input  logic                         i_w_ready,
   input  logic                         i_err_clr,
   output logic                         o_timeout_err,
   output logic [15:0]                  o_wr_cnt
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned IdW1 = IdW + 1;
   localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [IdW:0]      NumReqW = IdW1'(NUM_REQ);
   localparam logic [TmrW-1:0]   TmrLast = TmrW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWrLo,
      StWrHi,
      StHandshake,
      StDone
   } state_e;

   state_e              state_q;
   logic [IdW-1:0]      ptr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         data_q;
   logic [TmrW-1:0]     timer_q;
   logic                ready_meta_q;
   logic                ready_s_q;

   logic                rr_found;
   logic [IdW-1:0]      rr_winner;
   logic [IdW:0]        cand;
   logic [IdW:0]        ptr_nxt;

   // Round-robin search: first asserted request at or after ptr_q, wrapping mod NUM_REQ.
   // One extra bit on cand/ptr_nxt keeps the wrap correct for non-power-of-two NUM_REQ.
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = '0;
      cand      = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         cand = {1'b0, ptr_q} + IdW1'(i);
         if (cand >= NumReqW) begin
            cand = cand - NumReqW;
         end
         if (!rr_found && i_req[cand[IdW-1:0]]) begin
            rr_found  = 1'b1;
            rr_winner = cand[IdW-1:0];
         end
      end
      ptr_nxt = {1'b0, rr_winner} + IdW1'(1);
      if (ptr_nxt >= NumReqW) begin
         ptr_nxt = ptr_nxt - NumReqW;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= StIdle;
         ptr_q         <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         timer_q       <= '0;
         ready_meta_q  <= 1'b0;
         ready_s_q     <= 1'b0;
         o_ack         <= '0;
         o_busy        <= 1'b0;
         o_gnt_id      <= '0;
         o_ram_addr    <= '0;
         o_ram_ce      <= 1'b0;
         o_ram_we      <= 1'b0;
         o_ram_din     <= '0;
         o_w_valid     <= 1'b0;
         o_timeout_err <= 1'b0;
         o_wr_cnt      <= '0;
      end else begin
         // 2-flop synchronizer for the DSP's ready
         ready_meta_q <= i_w_ready;
         ready_s_q    <= ready_meta_q;

         o_ack <= '0;
         // A timeout set later in this block overrides the clear
         if (i_err_clr) begin
            o_timeout_err <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               o_ram_ce  <= 1'b0;
               o_ram_we  <= 1'b0;
               o_w_valid <= 1'b0;
               if (i_en && rr_found) begin
                  // Shadow copies decouple the in-flight write from later input changes
                  addr_q   <= i_addr[int'(rr_winner) * int'(ADDR_W) +: ADDR_W];
                  data_q   <= i_data[int'(rr_winner) * 32 +: 32];
                  o_gnt_id <= rr_winner;
                  ptr_q    <= ptr_nxt[IdW-1:0];
                  o_busy   <= 1'b1;
                  state_q  <= StWrLo;
               end
            end
            StWrLo: begin
               o_ram_ce   <= 1'b1;
               o_ram_we   <= 1'b1;
               o_ram_addr <= addr_q;
               o_ram_din  <= data_q[15:0];
               timer_q    <= '0;
               state_q    <= StWrHi;
            end
            StWrHi: begin
               o_ram_ce   <= 1'b1;
               o_ram_we   <= 1'b1;
               o_ram_addr <= addr_q + ADDR_W'(1);
               o_ram_din  <= data_q[31:16];
               state_q    <= StHandshake;
            end
            StHandshake: begin
               o_ram_ce  <= 1'b0;
               o_ram_we  <= 1'b0;
               o_w_valid <= 1'b1;
               if (ready_s_q) begin
                  state_q <= StDone;
               end else if (timer_q == TmrLast) begin
                  o_timeout_err <= 1'b1;
                  state_q       <= StDone;
               end else begin
                  timer_q <= timer_q + TmrW'(1);
               end
            end
            StDone: begin
               o_w_valid        <= 1'b0;
               o_ack[o_gnt_id]  <= 1'b1;
               o_wr_cnt         <= o_wr_cnt + 16'd1;
               o_busy           <= 1'b0;
               state_q          <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
